// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax front-end sequencer.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package softmax_pkg;

  // bf16 operand as seen by the power-of-two scaling stage
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] mant;
  } bf16_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [15:0]       BF16_ONE  = 16'h3F80;
  localparam logic signed [7:0] LOGIT_MIN = 8'sh80;

  // Clamp a 9-bit signed difference into the signed 8-bit shift range
  function automatic logic signed [7:0] sat8(input logic signed [8:0] d);
    if (d[8] && !d[7]) begin
      return 8'sh80;
    end else if (!d[8] && d[7]) begin
      return 8'sh7F;
    end else begin
      return d[7:0];
    end
  endfunction

endpackage

// File: rtl/softmax_vec_buf.sv
// Vector buffer: VEC_LEN x 8-bit logits (plus a mask bit with SOFTMAX_MASK_EN).
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the sequencer owns all flow control.
module softmax_vec_buf #(
  parameter int VEC_LEN = 16,
  localparam int AW = $clog2(VEC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [7:0]    wr_data,
`ifdef SOFTMAX_MASK_EN
  input  logic                 wr_mask,
  output logic                 rd_mask,
`endif
  input  logic [AW-1:0]        rd_addr,
  output logic signed [7:0]    rd_data
);

  logic signed [7:0] mem [VEC_LEN];
`ifdef SOFTMAX_MASK_EN
  logic [VEC_LEN-1:0] mask_mem;
`endif

  // Single write port; contents are cleared on reset so stale vectors never leak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        mem[i] <= '0;
      end
`ifdef SOFTMAX_MASK_EN
      mask_mem <= '0;
`endif
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
`ifdef SOFTMAX_MASK_EN
      mask_mem[wr_addr] <= wr_mask;
`endif
    end
  end

  assign rd_data = mem[rd_addr];
`ifdef SOFTMAX_MASK_EN
  assign rd_mask = mask_mem[rd_addr];
`endif

endmodule

// File: rtl/softmax_shift_seq.sv
// Collects one vector of int8 logits, then replays it as (bf16 seed, x - max) pairs.
// Latency: first pair valid the cycle after the closing input; 1 pair/cycle thereafter.
// Backpressure: out_ready low holds the pair; in_ready is low for the whole replay.
// Optional SOFTMAX_MASK_EN adds in_mask: masked elements skip the max and emit (0, 0).
module softmax_shift_seq
  import softmax_pkg::*;
#(
  parameter int          VEC_LEN = 16,
  parameter logic [15:0] SEED    = BF16_ONE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] in_data,
  input  logic              in_last,
`ifdef SOFTMAX_MASK_EN
  input  logic              in_mask,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_a,
  output logic signed [7:0] out_shift,
  output logic              out_last
);

  localparam int AW = $clog2(VEC_LEN);
  localparam int CW = $clog2(VEC_LEN + 1);

  state_t            state_q, state_d;
  logic              live_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     len_q;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     rd_nxt;
  logic signed [7:0] max_q;
  logic signed [7:0] max_upd;
  bf16_t             a_q;
  logic signed [7:0] shift_q;
  logic              last_q;

  logic              in_fire, out_fire, close, rd_last, emit_done;
  logic              in_masked;
  logic [AW-1:0]     rd_addr;
  logic signed [7:0] rd_data;
  logic              rd_mask;

  // Next pair to register, selected between the closing load and the replay advance
  logic signed [7:0] pair_elem;
  logic signed [7:0] pair_max;
  logic              pair_mask;
  logic              pair_last;
  logic signed [8:0] pair_diff;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign close     = in_fire & (in_last | (count_q == CW'(VEC_LEN - 1)));
  assign rd_last   = (CW'(rd_q) == len_q - CW'(1));
  assign emit_done = out_fire & rd_last;
  assign rd_nxt    = (rd_q == AW'(VEC_LEN - 1)) ? '0 : rd_q + AW'(1);
  assign rd_addr   = (state_q == EMIT) ? rd_nxt : '0;

`ifdef SOFTMAX_MASK_EN
  assign in_masked = in_mask;
`else
  assign in_masked = 1'b0;
  assign rd_mask   = 1'b0;
`endif

  assign max_upd = (!in_masked && (in_data > max_q)) ? in_data : max_q;

  softmax_vec_buf #(.VEC_LEN(VEC_LEN)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_fire),
    .wr_addr (AW'(count_q)),
    .wr_data (in_data),
`ifdef SOFTMAX_MASK_EN
    .wr_mask (in_mask),
    .rd_mask (rd_mask),
`endif
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Pair source: on close, element 0 may be the logit arriving this very cycle
  always_comb begin
    pair_elem = rd_data;
    pair_mask = rd_mask;
    pair_max  = max_q;
    pair_last = ((CW'(rd_q) + CW'(2)) == len_q);
    if (state_q == LOAD) begin
      pair_max  = max_upd;
      pair_last = (count_q == '0);
      if (count_q == '0) begin
        pair_elem = in_data;
        pair_mask = in_masked;
      end
    end
    pair_diff = {pair_elem[7], pair_elem} - {pair_max[7], pair_max};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (close)     state_d = EMIT;
      EMIT:    if (emit_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // FSM outputs; live_q keeps in_ready low through reset and its release edge
  always_comb begin
    in_ready  = live_q & (state_q == LOAD);
    out_valid = (state_q == EMIT);
  end

  // Marks the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Element counter, running max, vector length and replay index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      len_q   <= '0;
      rd_q    <= '0;
      max_q   <= LOGIT_MIN;
    end else if (in_fire) begin
      count_q <= count_q + CW'(1);
      max_q   <= max_upd;
      if (close) begin
        len_q <= count_q + CW'(1);
        rd_q  <= '0;
      end
    end else if (emit_done) begin
      count_q <= '0;
      max_q   <= LOGIT_MIN;
    end else if (out_fire) begin
      rd_q <= rd_nxt;
    end
  end

  // Output pair register: loads on close and on every non-final handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
    end else if (close || (out_fire && !rd_last)) begin
      a_q     <= pair_mask ? bf16_t'(16'h0000) : bf16_t'(SEED);
      shift_q <= pair_mask ? 8'sd0 : sat8(pair_diff);
      last_q  <= pair_last;
    end
  end

  assign out_a     = a_q;
  assign out_shift = shift_q;
  assign out_last  = last_q;

endmodule
